// File: rtl/panel_pkg.sv
// Shared constants and types for the front-panel input conditioner.
// Channel indices, debounce defaults and the per-channel event bundle.
package panel_pkg;

    localparam int BTN_RUN        = 0;
    localparam int BTN_CONTINUE   = 1;
    localparam int DEBOUNCE_SIM   = 16;
    localparam int DEBOUNCE_BOARD = 500000;

    typedef struct packed {
        logic held;
        logic press;
        logic rel;
        logic rpt;
    } btn_evt_t;

    // Counter width for a count range of n values, never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One push-button channel: two-flop synchroniser, debounce counter,
// press/release edge pulses and optional auto-repeat.
module btn_debounce_ch
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     btn_n,
    output btn_evt_t evt,
    output logic     press_nxt
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          btn_p0;
    logic          btn_p1;
    logic          sync_btn;
    logic [CW-1:0] cnt;
    logic          held;
    logic          press;
    logic          rel;
    logic          rpt;
    logic          accept;

    // Synchroniser stage: flops idle at 1 (released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_p0 <= 1'b1;
            btn_p1 <= 1'b1;
        end else begin
            btn_p0 <= btn_n;
            btn_p1 <= btn_p0;
        end
    end

    assign sync_btn  = ~btn_p1;
    assign accept    = (sync_btn != held) && (cnt == CNT_LAST);
    assign press_nxt = accept && !held;

    // Debounce stage: pulses register on the same edge that flips held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            held  <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= accept && !held;
            rel   <= accept && held;
            if ((sync_btn == held) || accept)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (accept)
                held <= ~held;
        end
    end

    generate
        if (REPEAT_CYCLES > 0) begin : g_rpt
            localparam int            RW       = cnt_width(REPEAT_CYCLES);
            localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

            logic [RW-1:0] rcnt;
            logic          rpt_q;

            // Repeat stage: idle while released and on the accept edge in
            // either direction, so it never lands on press or after release.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rcnt  <= '0;
                    rpt_q <= 1'b0;
                end else if (!held || accept) begin
                    rcnt  <= '0;
                    rpt_q <= 1'b0;
                end else if (rcnt == RPT_LAST) begin
                    rcnt  <= '0;
                    rpt_q <= 1'b1;
                end else begin
                    rcnt  <= rcnt + 1'b1;
                    rpt_q <= 1'b0;
                end
            end

            assign rpt = rpt_q;
        end else begin : g_norpt
            assign rpt = 1'b0;
        end
    endgenerate

    assign evt.held  = held;
    assign evt.press = press;
    assign evt.rel   = rel;
    assign evt.rpt   = rpt;

endmodule

// File: rtl/panel_input_conditioner.sv
// Front-panel input block: NUM_BTN debounced button channels plus a
// synchronised switch bank with a snapshot taken on the SNAP_CH press.
module panel_input_conditioner
    import panel_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    parameter int REPEAT_CYCLES   = 0,
    parameter int SNAP_CH         = BTN_RUN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTN-1:0]  btn_n,
    input  logic [SW_WIDTH-1:0] sw,
    output logic [NUM_BTN-1:0]  held,
    output logic [NUM_BTN-1:0]  press_pulse,
    output logic [NUM_BTN-1:0]  release_pulse,
    output logic [NUM_BTN-1:0]  repeat_pulse,
    output logic [SW_WIDTH-1:0] sw_sync,
    output logic [SW_WIDTH-1:0] sw_snap
);

    btn_evt_t            evt [NUM_BTN];
    logic [NUM_BTN-1:0]  press_nxt;
    logic [SW_WIDTH-1:0] sw_p0;
    logic [SW_WIDTH-1:0] sw_p1;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_n     (btn_n[i]),
            .evt       (evt[i]),
            .press_nxt (press_nxt[i])
        );

        assign held[i]          = evt[i].held;
        assign press_pulse[i]   = evt[i].press;
        assign release_pulse[i] = evt[i].rel;
        assign repeat_pulse[i]  = evt[i].rpt;
    end

    // Switch synchroniser stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_p0 <= '0;
            sw_p1 <= '0;
        end else begin
            sw_p0 <= sw;
            sw_p1 <= sw_p0;
        end
    end

    assign sw_sync = sw_p1;

    // Snapshot loads on the edge that raises press_pulse[SNAP_CH].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sw_snap <= '0;
        else if (press_nxt[SNAP_CH])
            sw_snap <= sw_p1;
    end

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Scoreboard bench for panel_input_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_CYCLES=8: expected pulse events are queued with their cycle.
`timescale 1ns/1ps
module tb_panel_input_conditioner;

    localparam int NB  = 2;
    localparam int SWW = 16;
    localparam int DB  = 4;
    localparam int RP  = 8;
    localparam int LAT = DB + 2;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_RPT   = 2;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [NB-1:0]  btn_n = '1;
    logic [SWW-1:0] sw    = '0;
    logic [NB-1:0]  held;
    logic [NB-1:0]  press_pulse;
    logic [NB-1:0]  release_pulse;
    logic [NB-1:0]  repeat_pulse;
    logic [SWW-1:0] sw_sync;
    logic [SWW-1:0] sw_snap;

    int n_vec  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    int sb[$];
    bit mon_en = 1'b0;

    panel_input_conditioner #(
        .NUM_BTN         (NB),
        .SW_WIDTH        (SWW),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RP),
        .SNAP_CH         (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_n         (btn_n),
        .sw            (sw),
        .held          (held),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse),
        .sw_sync       (sw_sync),
        .sw_snap       (sw_snap)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int ekey(input int c, input int kind, input int ch);
        return c * 64 + kind * 8 + ch;
    endfunction

    // Event key reads back as cycle*64 + kind*8 + channel.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic val, input int kind);
        btn_n[ch] = val;
        sb.push_back(ekey(cyc + LAT, kind, ch));
    endtask

    logic [NB-1:0] pv;

    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && (sb[0] / 64) < cyc) begin
                chk("missed_evt", -1, sb[0]);
                void'(sb.pop_front());
            end
            for (int k = 0; k < 3; k++) begin
                case (k)
                    K_PRESS: pv = press_pulse;
                    K_REL:   pv = release_pulse;
                    default: pv = repeat_pulse;
                endcase
                for (int c = 0; c < NB; c++) begin
                    if (pv[c]) begin
                        if (sb.size() > 0 && (sb[0] / 64) == cyc)
                            chk("evt", ekey(cyc, k, c), sb.pop_front());
                        else
                            chk("unexpected_evt", ekey(cyc, k, c), -1);
                    end
                end
            end
        end
    end

    initial begin
        int p;
        int m;

        step(3);
        chk("rst_held", held, 0);
        chk("rst_press", press_pulse, 0);
        chk("rst_release", release_pulse, 0);
        chk("rst_repeat", repeat_pulse, 0);
        chk("rst_sw_sync", sw_sync, 0);
        chk("rst_sw_snap", sw_snap, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(5);

        // Clean press on Run with a stable switch pattern.
        sw = 16'h0014;
        step(4);
        chk("sw_sync", sw_sync, 16'h0014);
        drive(0, 1'b0, K_PRESS);
        step(LAT - 1);
        chk("clean_held_early", held[0], 0);
        step(1);
        chk("clean_held", held[0], 1);
        chk("clean_press", press_pulse, 2'b01);
        chk("clean_snap", sw_snap, 16'h0014);
        step(1);
        chk("clean_press_one_cycle", press_pulse, 2'b00);
        drive(0, 1'b1, K_REL);
        step(LAT);
        chk("clean_released", held[0], 0);
        step(8);

        // Glitch of three cycles on Continue is rejected.
        btn_n[1] = 1'b0;
        step(3);
        btn_n[1] = 1'b1;
        step(4);
        chk("glitch_held_mid", held[1], 0);
        step(8);
        chk("glitch_held", held[1], 0);

        // Bounce for ten cycles, then settle pressed.
        for (int i = 0; i < 10; i++) begin
            btn_n[1] = i[0];
            step(1);
        end
        drive(1, 1'b0, K_PRESS);
        step(LAT);
        chk("bounce_held", held[1], 1);
        step(1);
        drive(1, 1'b1, K_REL);
        step(LAT + 8);

        // Auto-repeat on Run: repeats every RP cycles, none after release.
        drive(0, 1'b0, K_PRESS);
        p = cyc + LAT;
        for (int r = 1; r <= 4; r++)
            sb.push_back(ekey(p + r * RP, K_RPT, 0));
        step(LAT + 4 * RP);
        drive(0, 1'b1, K_REL);
        step(LAT - 1);
        chk("rpt_held_before_release", held[0], 1);
        step(RP + 12);

        // Simultaneous presses; snapshot follows Run only.
        sw = 16'h0003;
        step(4);
        btn_n = 2'b00;
        sb.push_back(ekey(cyc + LAT, K_PRESS, 0));
        sb.push_back(ekey(cyc + LAT, K_PRESS, 1));
        step(LAT);
        chk("simul_press", press_pulse, 2'b11);
        chk("simul_snap", sw_snap, 16'h0003);
        btn_n = 2'b11;
        sb.push_back(ekey(cyc + LAT, K_REL, 0));
        sb.push_back(ekey(cyc + LAT, K_REL, 1));
        step(LAT + 4);
        sw = 16'h0002;
        step(4);
        drive(1, 1'b0, K_PRESS);
        step(LAT);
        chk("cont_press", press_pulse, 2'b10);
        chk("cont_snap_kept", sw_snap, 16'h0003);
        step(1);
        drive(1, 1'b1, K_REL);
        step(LAT + 4);

        // Reset while Run is mid-debounce, button held through reset.
        btn_n[0] = 1'b0;
        step(4);
        rst_n = 1'b0;
        #1;
        chk("midrst_held", held, 0);
        chk("midrst_sw_sync", sw_sync, 0);
        chk("midrst_sw_snap", sw_snap, 0);
        step(3);
        chk("midrst_pulses", {press_pulse, release_pulse, repeat_pulse}, 0);
        rst_n = 1'b0;
        m = cyc;
        rst_n = 1'b1;
        sb.push_back(ekey(m + LAT, K_PRESS, 0));
        step(LAT - 1);
        chk("postrst_held_early", held[0], 0);
        step(1);
        chk("postrst_held", held[0], 1);
        chk("postrst_snap", sw_snap, 16'h0002);
        step(1);
        drive(0, 1'b1, K_REL);
        step(LAT + 6);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
